// File: rtl/plot_stream_arbiter_pkg.sv
// Shared widths, screen bounds and FSM encodings for the
// pixel-stream arbiter in front of the VGA adapter.
package plot_stream_arbiter_pkg;

  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int COLOR_W_DEF  = 3;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/plot_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or
// after the pointer, modulo N.
module plot_stream_arbiter_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/plot_stream_arbiter.sv
// Shares the VGA pixel-write port between renderers: burst grant,
// round-robin rotation, clipping and an idle-burst watchdog.
module plot_stream_arbiter
  import plot_stream_arbiter_pkg::*;
#(
  parameter int NUM_SRC       = 3,
  parameter int X_W           = X_W_DEF,
  parameter int Y_W           = Y_W_DEF,
  parameter int COLOR_W       = COLOR_W_DEF,
  parameter int SCREEN_WIDTH  = SCREEN_W_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_H_DEF,
  parameter int TIMEOUT       = 1023
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC-1:0]         src_plot,
  input  logic [NUM_SRC*X_W-1:0]     src_x,
  input  logic [NUM_SRC*Y_W-1:0]     src_y,
  input  logic [NUM_SRC*COLOR_W-1:0] src_color,
  output logic [NUM_SRC-1:0]         src_grant,
  output logic [X_W-1:0]             out_x,
  output logic [Y_W-1:0]             out_y,
  output logic [COLOR_W-1:0]         out_color,
  output logic                       plot,
  output logic                       out_pause,
  output logic                       timeout_err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [X_W:0]    SW_LIM = (X_W + 1)'(SCREEN_WIDTH);
  localparam logic [Y_W:0]    SH_LIM = (Y_W + 1)'(SCREEN_HEIGHT);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   c_q, c_d;
  logic                 plot_q, plot_d;
  logic                 err_q, err_d;

  logic [NUM_SRC-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic                 sel_req;
  logic                 sel_plot;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOR_W-1:0]   sel_c;
  logic                 in_bounds;
  logic [WD_W-1:0]      wd_inc;
  logic                 revoke;

  plot_stream_arbiter_rr_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (src_req),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign sel_req   = src_req[idx_q];
  assign sel_plot  = src_plot[idx_q];
  assign sel_x     = src_x[int'(idx_q)*X_W +: X_W];
  assign sel_y     = src_y[int'(idx_q)*Y_W +: Y_W];
  assign sel_c     = src_color[int'(idx_q)*COLOR_W +: COLOR_W];
  assign in_bounds = ({1'b0, sel_x} < SW_LIM) &&
                     ({1'b0, sel_y} < SH_LIM);

  // Saturating idle counter; TIMEOUT of 0 never revokes.
  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
  assign revoke = (TIMEOUT != 0) && !sel_plot && (wd_inc == WD_MAX);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          wd_d    = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        x_d    = sel_x;
        y_d    = sel_y;
        c_d    = sel_c;
        plot_d = sel_plot & in_bounds;
        wd_d   = sel_plot ? '0 : wd_inc;
        if (!sel_req) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (revoke) begin
          grant_d = '0;
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        rr_d    = (int'(idx_q) == NUM_SRC - 1) ? '0 : idx_q + 1'b1;
        wd_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      err_q   <= err_d;
    end
  end

  assign src_grant   = grant_q;
  assign out_x       = x_q;
  assign out_y       = y_q;
  assign out_color   = c_q;
  assign plot        = plot_q;
  assign timeout_err = err_q;
  assign out_pause   = (|src_req) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_plot_stream_arbiter.sv
// Directed bench for plot_stream_arbiter: grant order, clipping,
// foreign-pixel rejection, watchdog revoke and mid-burst reset.
module tb_plot_stream_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  src_req;
  logic [2:0]  src_plot;
  logic [23:0] src_x;
  logic [20:0] src_y;
  logic [8:0]  src_color;
  logic [2:0]  src_grant;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_color;
  logic        plot;
  logic        out_pause;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  plot_stream_arbiter #(
    .NUM_SRC (3),
    .TIMEOUT (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .src_req     (src_req),
    .src_plot    (src_plot),
    .src_x       (src_x),
    .src_y       (src_y),
    .src_color   (src_color),
    .src_grant   (src_grant),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_color   (out_color),
    .plot        (plot),
    .out_pause   (out_pause),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic px(input int i, input logic [7:0] x,
                    input logic [6:0] y, input logic [2:0] c);
    src_x[i*8 +: 8]     = x;
    src_y[i*7 +: 7]     = y;
    src_color[i*3 +: 3] = c;
  endtask

  initial begin
    reset     = 1'b1;
    src_req   = '0;
    src_plot  = '0;
    src_x     = '0;
    src_y     = '0;
    src_color = '0;
    tick;
    tick;
    chk("rst_grant", 32'(src_grant), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_x", 32'(out_x), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_pause", 32'(out_pause), 0);
    reset = 1'b0;

    // single source burst
    src_req  = 3'b001;
    src_plot = 3'b001;
    px(0, 8'd5, 7'd7, 3'd3);
    #1;
    chk("pause_comb", 32'(out_pause), 1);
    tick;
    chk("t1_grant", 32'(src_grant), 32'b001);
    chk("t1_plot0", 32'(plot), 0);
    tick;
    chk("t1_plot", 32'(plot), 1);
    chk("t1_x", 32'(out_x), 5);
    chk("t1_y", 32'(out_y), 7);
    chk("t1_c", 32'(out_color), 3);
    src_req  = 3'b000;
    src_plot = 3'b000;
    tick;
    chk("t1_rel_grant", 32'(src_grant), 0);
    chk("t1_rel_plot", 32'(plot), 0);
    tick;
    chk("t1_idle_pause", 32'(out_pause), 0);

    // three simultaneous requesters, rr restarted at 0
    reset = 1'b1;
    tick;
    reset = 1'b0;
    src_req  = 3'b111;
    src_plot = 3'b111;
    for (int i = 0; i < 3; i++)
      px(i, 8'(10 + i), 7'(20 + i), 3'(i + 1));
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rr%0d_grant", i), 32'(src_grant), 32'(1 << i));
      chk($sformatf("rr%0d_gap2", i), 32'(plot), 0);
      tick;
      chk($sformatf("rr%0d_plot", i), 32'(plot), 1);
      chk($sformatf("rr%0d_x", i), 32'(out_x), 32'(10 + i));
      src_req[i] = 1'b0;
      tick;
      chk($sformatf("rr%0d_drop", i), 32'(src_grant), 0);
      chk($sformatf("rr%0d_last", i), 32'(plot), 1);
      chk($sformatf("rr%0d_lastx", i), 32'(out_x), 32'(10 + i));
      tick;
      chk($sformatf("rr%0d_gap1", i), 32'(plot), 0);
    end
    src_plot = 3'b000;

    // clipping on src 1, then foreign pixels from src 2
    src_req  = 3'b010;
    src_plot = 3'b010;
    px(1, 8'd160, 7'd5, 3'd1);
    tick;
    chk("clip_grant", 32'(src_grant), 32'b010);
    tick;
    chk("clip_x160_plot", 32'(plot), 0);
    chk("clip_x160_x", 32'(out_x), 160);
    px(1, 8'd159, 7'd5, 3'd1);
    tick;
    chk("clip_x159_plot", 32'(plot), 1);
    chk("clip_x159_x", 32'(out_x), 159);
    px(1, 8'd159, 7'd120, 3'd2);
    tick;
    chk("clip_y120_plot", 32'(plot), 0);
    chk("clip_y120_y", 32'(out_y), 120);
    src_req  = 3'b110;
    src_plot = 3'b110;
    px(1, 8'd100, 7'd50, 3'd4);
    px(2, 8'd77, 7'd33, 3'd6);
    tick;
    chk("fgn_grant", 32'(src_grant), 32'b010);
    chk("fgn_x", 32'(out_x), 100);
    chk("fgn_c", 32'(out_color), 4);
    src_req  = 3'b100;
    src_plot = 3'b100;
    tick;
    chk("fgn_drop", 32'(src_grant), 0);
    chk("fgn_drop_plot", 32'(plot), 0);
    tick;
    tick;
    chk("s2_grant", 32'(src_grant), 32'b100);
    tick;
    chk("s2_x", 32'(out_x), 77);
    chk("s2_plot", 32'(plot), 1);
    src_req  = 3'b000;
    src_plot = 3'b000;
    tick;
    tick;
    tick;

    // watchdog: src 0 idles inside its burst
    src_req = 3'b011;
    tick;
    chk("wd_grant", 32'(src_grant), 32'b001);
    tick;
    tick;
    tick;
    chk("wd_hold", 32'(src_grant), 32'b001);
    chk("wd_err0", 32'(timeout_err), 0);
    tick;
    chk("wd_revoke", 32'(src_grant), 0);
    chk("wd_err1", 32'(timeout_err), 1);
    tick;
    tick;
    chk("wd_next", 32'(src_grant), 32'b010);
    chk("wd_sticky", 32'(timeout_err), 1);
    src_plot = 3'b010;
    px(1, 8'd3, 7'd4, 3'd5);
    tick;
    chk("wd_s1_plot", 32'(plot), 1);
    chk("wd_s1_x", 32'(out_x), 3);

    // reset in the middle of a burst
    reset = 1'b1;
    tick;
    chk("mr_grant", 32'(src_grant), 0);
    chk("mr_plot", 32'(plot), 0);
    chk("mr_err", 32'(timeout_err), 0);
    reset    = 1'b0;
    src_req  = 3'b000;
    src_plot = 3'b000;
    #1;
    chk("mr_idle", 32'(out_pause), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
